// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x oversampling for the debug link.
// Delivers each good byte as o_rx_data plus a one-cycle o_rx_done_tick.
module uart_rx #(
  parameter int NB_DATA  = 8,
  parameter int N_TICKS  = 16,
  parameter int BAUD_DIV = 651,
  parameter int NB_DIV   = 10
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx,
  output logic [NB_DATA-1:0] o_rx_data,
  output logic               o_rx_done_tick,
  output logic               o_frame_err,
  output logic               o_busy
);

  localparam int NB_SCNT = $clog2(N_TICKS);
  localparam int NB_NCNT = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [NB_DIV-1:0]  DIV_LAST = NB_DIV'(BAUD_DIV - 1);
  localparam logic [NB_SCNT-1:0] S_MID    = NB_SCNT'(N_TICKS / 2 - 1);
  localparam logic [NB_SCNT-1:0] S_LAST   = NB_SCNT'(N_TICKS - 1);
  localparam logic [NB_NCNT-1:0] N_LAST   = NB_NCNT'(NB_DATA - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic               rx_meta_q;
  logic               rx_s_q;
  logic [NB_DIV-1:0]  div_q;
  logic               s_tick;

  state_e             state_q,   state_d;
  logic [NB_SCNT-1:0] s_cnt_q,   s_cnt_d;
  logic [NB_NCNT-1:0] n_cnt_q,   n_cnt_d;
  logic [NB_DATA-1:0] b_reg_q,   b_reg_d;
  logic [NB_DATA-1:0] rx_data_q, rx_data_d;
  logic               done_q,    done_d;
  logic               err_q,     err_d;
  logic               busy_q;

  // NOTE: synchronizer flops reset to 1 (idle line) so reset release is not
  // mistaken for a start bit while the real line is high.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Free-running divider: the tick phase is independent of frame boundaries.
  assign s_tick = (div_q == DIV_LAST);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      div_q <= '0;
    end else if (s_tick) begin
      div_q <= '0;
    end else begin
      div_q <= div_q + NB_DIV'(1);
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge value of its inputs regardless of process ordering.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      n_cnt_q   <= '0;
      b_reg_q   <= '0;
      rx_data_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_cnt_q   <= s_cnt_d;
      n_cnt_q   <= n_cnt_d;
      b_reg_q   <= b_reg_d;
      rx_data_q <= rx_data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= (state_q != IDLE);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    s_cnt_d   = s_cnt_q;
    n_cnt_d   = n_cnt_q;
    b_reg_d   = b_reg_q;
    rx_data_d = rx_data_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (s_tick) begin
          if (s_cnt_q == S_MID) begin
            // A high line at mid start bit was only a glitch.
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      DATA: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            b_reg_d = {rx_s_q, b_reg_q[NB_DATA-1:1]};
            if (n_cnt_q == N_LAST) begin
              state_d = STOP;
            end else begin
              n_cnt_d = n_cnt_q + NB_NCNT'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      STOP: begin
        if (s_tick) begin
          if (s_cnt_q == S_LAST) begin
            state_d = IDLE;
            s_cnt_d = '0;
            if (rx_s_q) begin
              rx_data_d = b_reg_q;
              done_d    = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + NB_SCNT'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign o_rx_data      = rx_data_q;
  assign o_rx_done_tick = done_q;
  assign o_frame_err    = err_q;
  assign o_busy         = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus random bytes,
// compared against a frame-level model of what the line carried.
module tb_uart_rx;

  localparam int NB_DATA  = 8;
  localparam int N_TICKS  = 16;
  localparam int BAUD_DIV = 4;
  localparam int NB_DIV   = 3;
  localparam int BIT_CLKS = N_TICKS * BAUD_DIV;

  // Stop bit is sampled 9.5 bit periods after the start edge, plus tick
  // phase and synchronizer/register latency.
  localparam int LAT_NOM = (2 * (NB_DATA + 1) + 1) * BIT_CLKS / 2;
  localparam int LAT_MIN = LAT_NOM - 8;
  localparam int LAT_MAX = LAT_NOM + 12;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx;
  logic [NB_DATA-1:0] rx_data;
  logic               done_tick;
  logic               frame_err;
  logic               busy;

  uart_rx #(
    .NB_DATA  (NB_DATA),
    .N_TICKS  (N_TICKS),
    .BAUD_DIV (BAUD_DIV),
    .NB_DIV   (NB_DIV)
  ) dut (
    .i_clock        (clk),
    .i_reset        (rst_n),
    .i_rx           (rx),
    .o_rx_data      (rx_data),
    .o_rx_done_tick (done_tick),
    .o_frame_err    (frame_err),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled away from the active edge.
  logic [7:0] done_data_q[$];
  int         done_time_q[$];
  int         err_events = 0;
  int         both_seen  = 0;
  int         long_done  = 0;
  int         long_err   = 0;
  int         busy_seen  = 0;
  logic       prev_done  = 1'b0;
  logic       prev_err   = 1'b0;

  always @(negedge clk) begin
    if (done_tick) begin
      done_data_q.push_back(rx_data);
      done_time_q.push_back(cyc);
    end
    if (frame_err) err_events++;
    if (done_tick && frame_err) both_seen++;
    if (done_tick && prev_done) long_done++;
    if (frame_err && prev_err) long_err++;
    if (busy) busy_seen++;
    prev_done = done_tick;
    prev_err  = frame_err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  // good_stop=0 holds the stop bit low only past its sample point, then idles.
  task automatic send_frame(input logic [7:0] b, input bit good_stop, input bit chk_busy,
                            output int t_start);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < NB_DATA; i++) begin
      drive_bit(b[i]);
      if (chk_busy && i == 3) check("busy_mid_frame", busy, 1);
    end
    if (good_stop) begin
      drive_bit(1'b1);
    end else begin
      rx = 1'b0;
      repeat (40) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLKS - 40) @(negedge clk);
    end
  endtask

  task automatic clear_events();
    done_data_q.delete();
    done_time_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [7:0] stream[$];
    int         starts[$];
    int         t0;
    int         lat;
    int         gap;
    int         err_base;
    logic [7:0] model_data;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (5) @(negedge clk);

    // 1. reset values
    check("rst_data", rx_data, 0);
    check("rst_done", done_tick, 0);
    check("rst_err", frame_err, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    busy_seen = 0;
    repeat (1000) @(negedge clk);
    check("idle_no_done", done_data_q.size(), 0);
    check("idle_no_err", err_events, 0);
    check("idle_busy_seen", busy_seen, 0);
    check("idle_data", rx_data, 0);

    // 2. single byte
    send_frame(8'hA5, 1'b1, 1'b1, t0);
    repeat (10) @(negedge clk);
    check("single_count", done_data_q.size(), 1);
    if (done_data_q.size() == 1) begin
      check("single_data", done_data_q[0], 8'hA5);
      lat = done_time_q[0] - t0;
      check("single_latency_in_window", (lat >= LAT_MIN) && (lat <= LAT_MAX), 1);
    end
    check("single_no_err", err_events, 0);
    check("single_pulse_width", long_done, 0);
    check("single_busy_after", busy, 0);
    check("single_held_data", rx_data, 8'hA5);
    clear_events();

    // 3. back-to-back stream: fixed bytes then random ones
    stream = '{8'h01, 8'h03, 8'hFF, 8'h00};
    for (int i = 0; i < 8; i++) stream.push_back(8'($urandom));
    foreach (stream[i]) begin
      send_frame(stream[i], 1'b1, 1'b0, t0);
      starts.push_back(t0);
    end
    repeat (10) @(negedge clk);
    check("stream_count", done_data_q.size(), stream.size());
    if (done_data_q.size() == stream.size()) begin
      foreach (stream[i]) begin
        check($sformatf("stream_data[%0d]", i), done_data_q[i], stream[i]);
        if (i > 0) begin
          gap = done_time_q[i] - done_time_q[i-1];
          check($sformatf("stream_spacing[%0d]", i),
                (gap >= BIT_CLKS * 10 - 16) && (gap <= BIT_CLKS * 10 + 16), 1);
        end
      end
    end
    check("stream_no_err", err_events, 0);
    check("stream_pulse_width", long_done, 0);
    model_data = stream[stream.size()-1];
    check("stream_held_data", rx_data, model_data);
    clear_events();

    // 4. start glitch followed by a real frame
    rx = 1'b0;
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (200) @(negedge clk);
    check("glitch_busy", busy, 0);
    check("glitch_no_done", done_data_q.size(), 0);
    check("glitch_no_err", err_events, 0);
    check("glitch_data_kept", rx_data, model_data);
    send_frame(8'h5A, 1'b1, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("post_glitch_count", done_data_q.size(), 1);
    if (done_data_q.size() == 1) check("post_glitch_data", done_data_q[0], 8'h5A);
    model_data = 8'h5A;
    clear_events();

    // 5. framing error
    err_base = err_events;
    send_frame(8'h3C, 1'b0, 1'b0, t0);
    repeat (200) @(negedge clk);
    check("ferr_count", err_events - err_base, 1);
    check("ferr_no_done", done_data_q.size(), 0);
    check("ferr_data_kept", rx_data, model_data);
    check("ferr_pulse_width", long_err, 0);
    check("never_done_and_err", both_seen, 0);
    check("ferr_busy_after", busy, 0);

    // 6. reset in the middle of bit 4 of 0x77, then a fresh frame
    err_base = err_events;
    t0 = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h77 >> i) & 8'h01));
    rx = 1'b1;
    repeat (20) @(negedge clk);
    check("midframe_busy_before_rst", busy, 1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midframe_rst_busy", busy, 0);
    check("midframe_rst_data", rx_data, 0);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("abort_no_done", done_data_q.size(), 0);
    check("abort_no_err", err_events - err_base, 0);
    check("abort_busy", busy, 0);
    send_frame(8'h12, 1'b1, 1'b0, t0);
    repeat (10) @(negedge clk);
    check("after_rst_count", done_data_q.size(), 1);
    if (done_data_q.size() == 1) check("after_rst_data", done_data_q[0], 8'h12);
    check("after_rst_no_err", err_events - err_base, 0);
    check("final_never_both", both_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
